// File: rtl/score_keeper_if.sv
// Event/score bundle between the game logic and the score keeper.
// HIGH_SCORE_EN adds the high_score signal to the bundle.
interface score_keeper_if;
  logic        new_game;
  logic        game_active;
  logic        pellet_eaten;
  logic        power_eaten;
  logic        ghost_eaten;
  logic        power_expired;
  logic [31:0] score;
  logic        extra_life;
`ifdef HIGH_SCORE_EN
  logic [31:0] high_score;

  modport master (
    output new_game, game_active, pellet_eaten, power_eaten, ghost_eaten, power_expired,
    input  score, extra_life, high_score
  );

  modport slave (
    input  new_game, game_active, pellet_eaten, power_eaten, ghost_eaten, power_expired,
    output score, extra_life, high_score
  );
`else
  modport master (
    output new_game, game_active, pellet_eaten, power_eaten, ghost_eaten, power_expired,
    input  score, extra_life
  );

  modport slave (
    input  new_game, game_active, pellet_eaten, power_eaten, ghost_eaten, power_expired,
    output score, extra_life
  );
`endif
endinterface

// File: rtl/score_keeper.sv
// Saturating game score with ghost chain and one-shot extra-life bonus.
// Optional feature macro: HIGH_SCORE_EN (adds a persistent high_score register).
//
//   state | meaning
//   CH0   | next ghost worth 200
//   CH1   | next ghost worth 400
//   CH2   | next ghost worth 800
//   CH3   | next ghost worth 1600 (saturates)
module score_keeper (
  input  logic           Clk,
  input  logic           Reset,
  score_keeper_if.slave  sk
);

  typedef enum logic [1:0] {CH0 = 2'd0, CH1 = 2'd1, CH2 = 2'd2, CH3 = 2'd3} chain_t;

  localparam logic [13:0] SCORE_MAX = 14'd9999;
  localparam logic [13:0] BONUS_AT  = 14'd5000;

  logic [13:0] score_q;
  chain_t      chain_q;
  logic        bonus_q;
  logic        extra_life_q;

  logic [13:0] ghost_pts;
  logic [13:0] points;
  logic [14:0] sum;
  logic [13:0] next_score;
  chain_t      next_chain;
  logic        crossing;

  always_comb begin
    ghost_pts = 14'd200;
    case (chain_q)
      CH0:     ghost_pts = 14'd200;
      CH1:     ghost_pts = 14'd400;
      CH2:     ghost_pts = 14'd800;
      CH3:     ghost_pts = 14'd1600;
      default: ghost_pts = 14'd200;
    endcase

    points = (sk.pellet_eaten ? 14'd10 : 14'd0)
           + (sk.power_eaten  ? 14'd50 : 14'd0)
           + (sk.ghost_eaten  ? ghost_pts : 14'd0);

    // Worst case 9999 + 1660 fits in 15 bits, so the compare never sees a wrap.
    sum        = {1'b0, score_q} + {1'b0, points};
    next_score = (sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : sum[13:0];

    // A power event ends the chain even when a ghost is eaten on the same cycle.
    next_chain = chain_q;
    if (sk.power_eaten || sk.power_expired)
      next_chain = CH0;
    else if (sk.ghost_eaten && (chain_q != CH3))
      next_chain = chain_t'(chain_q + 2'd1);

    crossing = !bonus_q && (score_q < BONUS_AT) && (next_score >= BONUS_AT);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      score_q      <= '0;
      chain_q      <= CH0;
      bonus_q      <= 1'b0;
      extra_life_q <= 1'b0;
    end else if (sk.new_game) begin
      score_q      <= '0;
      chain_q      <= CH0;
      bonus_q      <= 1'b0;
      extra_life_q <= 1'b0;
    end else begin
      extra_life_q <= 1'b0;
      if (sk.game_active) begin
        score_q <= next_score;
        chain_q <= next_chain;
        if (crossing) begin
          extra_life_q <= 1'b1;
          bonus_q      <= 1'b1;
        end
      end
    end
  end

  assign sk.score      = {18'd0, score_q};
  assign sk.extra_life = extra_life_q;

`ifdef HIGH_SCORE_EN
  logic [13:0] high_q;

  // Tracks the new score on the same edge; survives new_game, cleared only by Reset.
  always_ff @(posedge Clk) begin
    if (Reset)
      high_q <= '0;
    else if (!sk.new_game && sk.game_active && (next_score > high_q))
      high_q <= next_score;
  end

  assign sk.high_score = {18'd0, high_q};
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: chain values, saturation, bonus, new_game and reset.
module tb_score_keeper;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  score_keeper_if sk();

  score_keeper u_dut (
    .Clk   (clk),
    .Reset (reset),
    .sk    (sk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic p, input logic pw, input logic g, input logic ex, input logic ng);
    @(negedge clk);
    sk.pellet_eaten  = p;
    sk.power_eaten   = pw;
    sk.ghost_eaten   = g;
    sk.power_expired = ex;
    sk.new_game      = ng;
    @(posedge clk);
    #1;
    sk.pellet_eaten  = 1'b0;
    sk.power_eaten   = 1'b0;
    sk.ghost_eaten   = 1'b0;
    sk.power_expired = 1'b0;
    sk.new_game      = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sk.game_active = 1'b1;
    @(negedge clk);
    sk.pellet_eaten = 1'b1;
    sk.ghost_eaten  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (sk.score !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_score: got %0d want 0", sk.score);
    end
    vectors++;
    if (sk.extra_life !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_extra_life: got %b want 0", sk.extra_life);
    end
`ifdef HIGH_SCORE_EN
    vectors++;
    if (sk.high_score !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_high_score: got %0d want 0", sk.high_score);
    end
`endif
    sk.pellet_eaten = 1'b0;
    sk.ghost_eaten  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_pellets();
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0, 0);
      vectors++;
      if (sk.score !== 32'(10 * i)) begin
        miscompares++;
        $display("FAIL pellet_%0d: got %0d want %0d", i, sk.score, 10 * i);
      end
    end
    step(0, 1, 0, 0, 0);
    vectors++;
    if (sk.score !== 32'd80 || sk.extra_life !== 1'b0) begin
      miscompares++;
      $display("FAIL power_after_pellets: got %0d/%b want 80/0", sk.score, sk.extra_life);
    end
  endtask

  task automatic test_ghost_chain();
    int exp_seq[6] = '{50, 250, 650, 1450, 3050, 4650};
    step(0, 0, 0, 0, 1);
    vectors++;
    if (sk.score !== 32'd0) begin
      miscompares++;
      $display("FAIL chain_new_game: got %0d want 0", sk.score);
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 0) step(0, 1, 0, 0, 0);
      else        step(0, 0, 1, 0, 0);
      vectors++;
      if (sk.score !== 32'(exp_seq[i])) begin
        miscompares++;
        $display("FAIL chain_step_%0d: got %0d want %0d", i, sk.score, exp_seq[i]);
      end
    end
    step(0, 0, 0, 1, 0);
    vectors++;
    if (sk.score !== 32'd4650) begin
      miscompares++;
      $display("FAIL expire_no_points: got %0d want 4650", sk.score);
    end
    step(0, 0, 1, 0, 0);
    vectors++;
    if (sk.score !== 32'd4850) begin
      miscompares++;
      $display("FAIL expire_resets_chain: got %0d want 4850", sk.score);
    end
  endtask

  task automatic test_bonus();
    logic saw_extra;
    saw_extra = 1'b0;
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 434; i++) begin
      step(1, 0, 0, 0, 0);
      if (sk.extra_life !== 1'b0) saw_extra = 1'b1;
    end
    vectors++;
    if (sk.score !== 32'd4990 || saw_extra !== 1'b0) begin
      miscompares++;
      $display("FAIL bonus_setup: got %0d/%b want 4990/0", sk.score, saw_extra);
    end
    step(0, 1, 1, 0, 0);
    vectors++;
    if (sk.score !== 32'd5840 || sk.extra_life !== 1'b1) begin
      miscompares++;
      $display("FAIL bonus_cross: got %0d/%b want 5840/1", sk.score, sk.extra_life);
    end
    step(0, 0, 0, 0, 0);
    vectors++;
    if (sk.score !== 32'd5840 || sk.extra_life !== 1'b0) begin
      miscompares++;
      $display("FAIL bonus_one_cycle: got %0d/%b want 5840/0", sk.score, sk.extra_life);
    end
    step(0, 0, 1, 0, 0);
    vectors++;
    if (sk.score !== 32'd6040 || sk.extra_life !== 1'b0) begin
      miscompares++;
      $display("FAIL bonus_chain_ch0: got %0d/%b want 6040/0", sk.score, sk.extra_life);
    end
  endtask

  task automatic test_combined();
    step(1, 0, 1, 0, 0);
    vectors++;
    if (sk.score !== 32'd6450) begin
      miscompares++;
      $display("FAIL pellet_plus_ghost: got %0d want 6450", sk.score);
    end
    step(0, 0, 1, 1, 0);
    vectors++;
    if (sk.score !== 32'd7250) begin
      miscompares++;
      $display("FAIL ghost_with_expire: got %0d want 7250", sk.score);
    end
    step(0, 0, 1, 0, 0);
    vectors++;
    if (sk.score !== 32'd7450 || sk.extra_life !== 1'b0) begin
      miscompares++;
      $display("FAIL ghost_after_expire: got %0d/%b want 7450/0", sk.score, sk.extra_life);
    end
  endtask

  task automatic test_saturation();
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 134; i++) step(1, 0, 0, 0, 0);
    vectors++;
    if (sk.score !== 32'd9990) begin
      miscompares++;
      $display("FAIL sat_setup: got %0d want 9990", sk.score);
    end
    step(0, 0, 1, 0, 0);
    vectors++;
    if (sk.score !== 32'd9999) begin
      miscompares++;
      $display("FAIL sat_ghost: got %0d want 9999", sk.score);
    end
    step(1, 0, 0, 0, 0);
    vectors++;
    if (sk.score !== 32'd9999 || sk.extra_life !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_pellet: got %0d/%b want 9999/0", sk.score, sk.extra_life);
    end
`ifdef HIGH_SCORE_EN
    vectors++;
    if (sk.high_score !== 32'd9999) begin
      miscompares++;
      $display("FAIL sat_high_score: got %0d want 9999", sk.high_score);
    end
`endif
  endtask

  task automatic test_inactive_and_new_game();
    sk.game_active = 1'b0;
    step(1, 0, 0, 0, 0);
    vectors++;
    if (sk.score !== 32'd9999) begin
      miscompares++;
      $display("FAIL inactive_pellet: got %0d want 9999", sk.score);
    end
    step(1, 0, 0, 0, 1);
    vectors++;
    if (sk.score !== 32'd0) begin
      miscompares++;
      $display("FAIL new_game_inactive: got %0d want 0", sk.score);
    end
    step(0, 1, 1, 0, 0);
    vectors++;
    if (sk.score !== 32'd0) begin
      miscompares++;
      $display("FAIL inactive_events: got %0d want 0", sk.score);
    end
    sk.game_active = 1'b1;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
    for (int i = 0; i < 34; i++) step(1, 0, 0, 0, 0);
    vectors++;
    if (sk.score !== 32'd4990 || sk.extra_life !== 1'b0) begin
      miscompares++;
      $display("FAIL rebonus_setup: got %0d/%b want 4990/0", sk.score, sk.extra_life);
    end
    step(1, 0, 0, 0, 0);
    vectors++;
    if (sk.score !== 32'd5000 || sk.extra_life !== 1'b1) begin
      miscompares++;
      $display("FAIL rebonus_exact_5000: got %0d/%b want 5000/1", sk.score, sk.extra_life);
    end
    step(0, 0, 1, 0, 1);
    vectors++;
    if (sk.score !== 32'd0 || sk.extra_life !== 1'b0) begin
      miscompares++;
      $display("FAIL new_game_priority: got %0d/%b want 0/0", sk.score, sk.extra_life);
    end
    step(0, 0, 1, 0, 0);
    vectors++;
    if (sk.score !== 32'd200) begin
      miscompares++;
      $display("FAIL new_game_chain_ch0: got %0d want 200", sk.score);
    end
  endtask

  task automatic test_reset_mid_game();
    @(negedge clk);
    reset = 1'b1;
    sk.pellet_eaten = 1'b1;
    sk.ghost_eaten  = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (sk.score !== 32'd0 || sk.extra_life !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_game: got %0d/%b want 0/0", sk.score, sk.extra_life);
    end
    sk.pellet_eaten = 1'b0;
    sk.ghost_eaten  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 1, 0, 0);
    vectors++;
    if (sk.score !== 32'd200) begin
      miscompares++;
      $display("FAIL reset_chain_ch0: got %0d want 200", sk.score);
    end
  endtask

`ifdef HIGH_SCORE_EN
  task automatic test_high_score();
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 58; i++) step(1, 0, 0, 0, 0);
    vectors++;
    if (sk.score !== 32'd1230 || sk.high_score !== 32'd1230) begin
      miscompares++;
      $display("FAIL hs_game1: got %0d/%0d want 1230/1230", sk.score, sk.high_score);
    end
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 50; i++) step(1, 0, 0, 0, 0);
    vectors++;
    if (sk.score !== 32'd500 || sk.high_score !== 32'd1230) begin
      miscompares++;
      $display("FAIL hs_game2: got %0d/%0d want 500/1230", sk.score, sk.high_score);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (sk.high_score !== 32'd0) begin
      miscompares++;
      $display("FAIL hs_reset: got %0d want 0", sk.high_score);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask
`endif

  initial begin
    vectors          = 0;
    miscompares      = 0;
    reset            = 1'b1;
    sk.new_game      = 1'b0;
    sk.game_active   = 1'b0;
    sk.pellet_eaten  = 1'b0;
    sk.power_eaten   = 1'b0;
    sk.ghost_eaten   = 1'b0;
    sk.power_expired = 1'b0;

    test_reset();
    test_pellets();
    test_ghost_chain();
    test_bonus();
    test_combined();
    test_saturation();
    test_inactive_and_new_game();
    test_reset_mid_game();
`ifdef HIGH_SCORE_EN
    test_high_score();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
